// File: rtl/store_buffer.sv
// Commit-ordered store buffer: allocate at dispatch, fill at execute, retire via ROB,
// drain committed stores in order to memory, and answer load-forwarding lookups.
module store_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  localparam int IDW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  output logic [IDW-1:0]        alloc_id,
  input  logic                  exec_valid,
  input  logic [IDW-1:0]        exec_id,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [DATA_WIDTH-1:0] exec_data,
  input  logic [2:0]            exec_funct3,
  input  logic                  commit_valid,
  input  logic [IDW-1:0]        commit_id,
  input  logic                  flush,
  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [2:0]            mem_wr_funct3,
  input  logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  fwd_stall,
  output logic                  empty,
  output logic                  err
);
  localparam int PW = IDW + 1;
  localparam logic [2:0] F3_SW = 3'b010;

  logic [PW-1:0] head, cmt, tail, head_n, cmt_n, tail_n, count;
  logic [FIFO_DEPTH-1:0] valid, executed, valid_n, executed_n, wmatch, cand;
  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] addr;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] data;
  logic [FIFO_DEPTH-1:0][2:0] funct3;
  logic [IDW-1:0] head_idx, tail_idx, cmt_idx;
  logic full, alloc_fire, exec_ok, exec_wr, commit_ok, drain, err_set;
  logic unexec, yng_any, yng_cand;
  logic [DATA_WIDTH-1:0] yng_data;

  // Slot i lies in the circular window [lo, hi)
  function automatic logic in_rng(input logic [IDW-1:0] i, input logic [PW-1:0] lo,
                                  input logic [PW-1:0] hi);
    logic [IDW-1:0] off;
    off = i - lo[IDW-1:0];
    return {1'b0, off} < (hi - lo);
  endfunction

  assign head_idx    = head[IDW-1:0];
  assign tail_idx    = tail[IDW-1:0];
  assign cmt_idx     = cmt[IDW-1:0];
  assign count       = tail - head;
  assign full        = (count == PW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign alloc_ready = !full && !flush && !rst;
  assign alloc_id    = tail_idx;
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign exec_ok   = valid[exec_id] && in_rng(exec_id, cmt, tail);
  assign commit_ok = (commit_id == cmt_idx) && (cmt != tail) && executed[cmt_idx];
  assign cmt_n     = cmt + PW'(commit_valid && commit_ok);
  // Commit lands before flush, so only execs to entries younger than cmt_n are dropped
  assign exec_wr   = exec_valid && exec_ok && !(flush && in_rng(exec_id, cmt_n, tail));
  assign err_set   = (exec_valid && !exec_ok) || (commit_valid && !commit_ok);

  assign mem_wr_valid  = (head != cmt);
  assign mem_wr_addr   = addr[head_idx];
  assign mem_wr_data   = data[head_idx];
  assign mem_wr_funct3 = funct3[head_idx];
  assign drain         = mem_wr_valid && mem_wr_ready;

  assign head_n = head + PW'(drain);
  assign tail_n = flush ? cmt_n : tail + PW'(alloc_fire);

  always_comb begin
    valid_n    = valid;
    executed_n = executed;
    if (drain) valid_n[head_idx] = 1'b0;
    if (exec_wr) executed_n[exec_id] = 1'b1;
    if (alloc_fire) begin
      valid_n[tail_idx]    = 1'b1;
      executed_n[tail_idx] = 1'b0;
    end
    if (flush)
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (in_rng(IDW'(i), cmt_n, tail)) begin
          valid_n[i]    = 1'b0;
          executed_n[i] = 1'b0;
        end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      cmt      <= '0;
      tail     <= '0;
      valid    <= '0;
      executed <= '0;
      err      <= 1'b0;
    end else begin
      head     <= head_n;
      cmt      <= cmt_n;
      tail     <= tail_n;
      valid    <= valid_n;
      executed <= executed_n;
      err      <= err || err_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr   <= '0;
      data   <= '0;
      funct3 <= '0;
    end else if (exec_wr) begin
      addr[exec_id]   <= exec_addr;
      data[exec_id]   <= exec_data;
      funct3[exec_id] <= exec_funct3;
    end
  end

  // Unexecuted entries have no address yet, so they never count as a word match
  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_match
    assign wmatch[i] = valid[i] && executed[i] &&
                       (addr[i][ADDR_WIDTH-1:2] == fwd_addr[ADDR_WIDTH-1:2]);
    assign cand[i]   = wmatch[i] && (funct3[i] == F3_SW) && (addr[i][1:0] == fwd_addr[1:0]);
  end

  assign unexec = |(valid & ~executed);

  // Walk oldest to youngest so the last match seen is the youngest
  always_comb begin
    logic [IDW-1:0] idx;
    yng_any  = 1'b0;
    yng_cand = 1'b0;
    yng_data = '0;
    idx      = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      idx = head_idx + IDW'(k);
      if ((PW'(k) < count) && wmatch[idx]) begin
        yng_any  = 1'b1;
        yng_cand = cand[idx];
        yng_data = data[idx];
      end
    end
  end

  assign fwd_stall = unexec || (yng_any && !yng_cand);
  assign fwd_hit   = !unexec && yng_any && yng_cand;
  assign fwd_data  = fwd_hit ? yng_data : '0;
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a program-order queue model predicts outputs,
// expected memory writes are queued at commit and checked by an independent monitor.
module tb_store_buffer;
  localparam int D = 8;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic clk = 1'b0, rst = 1'b1;
  logic alloc_valid = 0, alloc_ready;
  logic [2:0] alloc_id;
  logic exec_valid = 0;
  logic [2:0] exec_id = 0;
  logic [31:0] exec_addr = 0, exec_data = 0;
  logic [2:0] exec_funct3 = 0;
  logic commit_valid = 0;
  logic [2:0] commit_id = 0;
  logic flush = 0;
  logic mem_wr_valid, mem_wr_ready = 0;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic [2:0] mem_wr_funct3;
  logic [31:0] fwd_addr = 0, fwd_data;
  logic fwd_hit, fwd_stall, empty, err;

  store_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_id(alloc_id), .exec_valid(exec_valid), .exec_id(exec_id), .exec_addr(exec_addr),
    .exec_data(exec_data), .exec_funct3(exec_funct3), .commit_valid(commit_valid),
    .commit_id(commit_id), .flush(flush), .mem_wr_valid(mem_wr_valid),
    .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_funct3(mem_wr_funct3), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .fwd_stall(fwd_stall), .empty(empty), .err(err));

  always #5 clk = ~clk;

  typedef struct { logic [2:0] id; bit cm; bit ex; logic [31:0] a; logic [31:0] d; logic [2:0] f; } ent_t;
  typedef struct { logic [31:0] a; logic [31:0] d; logic [2:0] f; } wr_t;
  ent_t q[$];       // live stores, oldest first
  wr_t  exp_wr[$];  // committed stores awaiting their memory write
  logic [2:0] head_id = 0;
  bit m_err = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int n_cm();
    int c = 0;
    while (c < q.size() && q[c].cm) c++;
    return c;
  endfunction

  task automatic model_fwd(output bit h, output bit s, output logic [31:0] d);
    int y = -1;
    h = 0; s = 0; d = 0;
    foreach (q[i]) if (!q[i].ex) s = 1;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].ex && q[i].a[31:2] == fwd_addr[31:2]) begin y = i; break; end
    if (!s && y >= 0) begin
      if (q[y].f == SW && q[y].a == fwd_addr) begin h = 1; d = q[y].d; end
      else s = 1;
    end
  endtask

  task automatic check_outputs();
    bit h, s;
    logic [31:0] d;
    logic [2:0] tid;
    bit wv;
    tid = head_id + 3'(q.size());
    wv = (q.size() > 0) ? q[0].cm : 1'b0;
    model_fwd(h, s, d);
    chk("alloc_ready", alloc_ready, (q.size() < D) && !flush);
    chk("alloc_id", alloc_id, tid);
    chk("mem_wr_valid", mem_wr_valid, wv);
    chk("empty", empty, q.size() == 0);
    chk("err", err, m_err);
    chk("fwd_hit", fwd_hit, h);
    chk("fwd_stall", fwd_stall, s);
    chk("fwd_data", fwd_data, d);
  endtask

  task automatic model_step();
    int ci, ei;
    bit c_ok, d_ok, a_ok;
    logic [2:0] tid;
    ci = n_cm(); ei = -1;
    tid  = head_id + 3'(q.size());
    a_ok = alloc_valid && q.size() < D && !flush;
    d_ok = mem_wr_ready && ci > 0;
    c_ok = 0;
    if (commit_valid && ci < q.size()) c_ok = (q[ci].id == commit_id) && q[ci].ex;
    for (int i = ci; i < q.size(); i++) if (q[i].id == exec_id) ei = i;
    if (exec_valid) begin
      if (ei < 0) m_err = 1;
      else if (!flush || (c_ok && ei == ci)) begin
        q[ei].ex = 1; q[ei].a = exec_addr; q[ei].d = exec_data; q[ei].f = exec_funct3;
      end
    end
    if (commit_valid && !c_ok) m_err = 1;
    if (c_ok) begin
      q[ci].cm = 1;
      exp_wr.push_back('{q[ci].a, q[ci].d, q[ci].f});
    end
    if (flush) while (q.size() > 0 && !q[q.size()-1].cm) void'(q.pop_back());
    if (d_ok) begin void'(q.pop_front()); head_id++; end
    if (a_ok) q.push_back('{tid, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0});
  endtask

  // One clock: outputs checked mid-cycle, model advanced on the edge, inputs free at +1
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; exec_valid = 0; commit_valid = 0; flush = 0;
  endtask

  task automatic exec(input logic [2:0] id, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f);
    exec_valid = 1; exec_id = id; exec_addr = a; exec_data = d; exec_funct3 = f;
  endtask

  task automatic commit(input logic [2:0] id);
    commit_valid = 1; commit_id = id;
  endtask

  // Assert reset immediately, confirm reset outputs, release after the next edge
  task automatic rst_now();
    rst = 1; idle(); mem_wr_ready = 0;
    q.delete(); exp_wr.delete(); head_id = 0; m_err = 0;
    #1;
    chk("rst_alloc_ready", alloc_ready, 0);
    chk("rst_alloc_id", alloc_id, 0);
    chk("rst_mem_wr_valid", mem_wr_valid, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_stall", fwd_stall, 0);
    chk("rst_empty", empty, 1);
    chk("rst_err", err, 0);
    chk("rst_mem_wr_addr", mem_wr_addr, 0);
    chk("rst_mem_wr_data", mem_wr_data, 0);
    chk("rst_mem_wr_funct3", mem_wr_funct3, 0);
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic gen_random();
    int ci, k;
    int un[$];
    logic [2:0] f;
    logic [31:0] a;
    idle();
    ci = n_cm();
    alloc_valid = ($urandom_range(0, 3) != 0);
    for (int i = ci; i < q.size(); i++) un.push_back(i);
    if (un.size() > 0 && $urandom_range(0, 9) < 6) begin
      k = un[$urandom_range(0, un.size() - 1)];
      case ($urandom_range(0, 3))
        0: f = SB;
        1: f = SH;
        default: f = SW;
      endcase
      a = 32'h200 + 32'($urandom_range(0, 3) * 4);
      if (f == SB) a = a + 32'($urandom_range(0, 3));
      if (f == SH) a = a + 32'($urandom_range(0, 1) * 2);
      exec(q[k].id, a, $urandom, f);
    end
    if (ci < q.size() && q[ci].ex && $urandom_range(0, 1) == 1) commit(q[ci].id);
    flush = ($urandom_range(0, 24) == 0);
    mem_wr_ready = ($urandom_range(0, 3) != 0);
    fwd_addr = 32'h200 + 32'($urandom_range(0, 15));
  endtask

  // Write-port monitor: head fields must match the oldest committed store until accepted
  always @(negedge clk) begin
    if (!rst && mem_wr_valid) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL mem_wr_unexpected: got addr %0h with no committed store pending", mem_wr_addr);
      end else begin
        chk("mem_wr_addr", mem_wr_addr, exp_wr[0].a);
        chk("mem_wr_data", mem_wr_data, exp_wr[0].d);
        chk("mem_wr_funct3", mem_wr_funct3, exp_wr[0].f);
        if (mem_wr_ready) void'(exp_wr.pop_front());
      end
    end
  end

  initial begin
    // Fill and full
    rst_now();
    for (int i = 0; i < D; i++) begin
      alloc_valid = 1;
      chk("fill_alloc_id", alloc_id, i);
      cycle();
    end
    chk("full_alloc_ready", alloc_ready, 0);
    cycle();
    chk("full_tail_kept", alloc_id, 0);
    idle();

    // Commit and drain with back-pressure
    rst_now();
    alloc_valid = 1; cycle(); idle();
    exec(0, 32'h100, 32'hDEADBEEF, SW); cycle(); idle();
    commit(0); cycle(); idle();
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", mem_wr_valid, 1);
      chk("hold_addr", mem_wr_addr, 32'h100);
      chk("hold_data", mem_wr_data, 32'hDEADBEEF);
      cycle();
    end
    mem_wr_ready = 1; cycle();
    chk("drain_empty", empty, 1);

    // Flush in the cycle id1 commits
    rst_now();
    alloc_valid = 1; repeat (4) cycle(); idle();
    exec(0, 32'h300, 32'hA0, SW); cycle(); idle();
    exec(1, 32'h304, 32'hA1, SW); cycle(); idle();
    commit(0); cycle(); idle();
    commit(1); flush = 1; cycle(); idle();
    chk("flush_alloc_id", alloc_id, 2);
    mem_wr_ready = 1; repeat (3) cycle();
    chk("flush_drained", empty, 1);

    // Forwarding
    rst_now();
    fwd_addr = 32'h200;
    alloc_valid = 1; repeat (2) cycle(); idle();
    exec(0, 32'h200, 32'h11, SW); cycle(); idle();
    exec(1, 32'h200, 32'h22, SW); cycle(); idle();
    chk("fwd_young_hit", fwd_hit, 1);
    chk("fwd_young_data", fwd_data, 32'h22);
    alloc_valid = 1; cycle(); idle();
    chk("fwd_unexec_stall", fwd_stall, 1);
    exec(2, 32'h201, 32'h33, SB); cycle(); idle();
    chk("fwd_sb_stall", fwd_stall, 1);
    chk("fwd_sb_nohit", fwd_hit, 0);
    fwd_addr = 32'h300; #1;
    chk("fwd_miss", {fwd_hit, fwd_stall}, 2'b00);
    cycle();

    // Protocol errors, then reset mid-drain
    rst_now();
    alloc_valid = 1; repeat (3) cycle(); idle();
    exec(0, 32'h400, 32'hC0, SW); cycle(); idle();
    commit(0); cycle(); idle();
    commit(3); cycle(); idle();
    chk("err_latch", err, 1);
    exec(1, 32'h404, 32'hC1, SW); cycle(); idle();
    commit(1); cycle(); idle();
    exec(6, 32'h408, 32'hC6, SW); cycle(); idle();
    mem_wr_ready = 1; cycle();
    chk("mid_drain_valid", mem_wr_valid, 1);
    rst_now();

    // Randomized traffic with wrap-around
    repeat (3000) begin
      gen_random();
      cycle();
    end
    idle(); flush = 1; mem_wr_ready = 1; cycle();
    idle(); repeat (12) cycle();
    chk("final_pending", exp_wr.size(), 0);
    chk("final_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
